sd_dev_cmd: RTL

Card-side SD CMD-line engine: the responder end of the host command path in `sdio_top`. It is the synthesizable counterpart to what the `sd_card` bench model does on CMD.
- Receives 48-bit host commands on `cmd_i`, checks CRC7 and the end bit, and presents index/argument to the card application logic.
- Serializes the application's response (R1/R3/R6/R7 48-bit, optionally R2 136-bit) back onto the CMD pad with the required N_CR spacing.

---
 rtl/sd_dev_pkg.sv | 24 ++
 rtl/sd_crc7.sv | 28 ++
 rtl/sd_dev_cmd.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sd_dev_pkg.sv
// Shared constants for the card-side SD CMD engine: response types, FSM
// state encoding, CRC7 polynomial and frame lengths.
// Latency: n/a. Backpressure: n/a.
package sd_dev_pkg;

    // resp_type encodings; 2'd3 is reserved and handled like RESP_NONE
    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_48   = 2'd1;
    localparam logic [1:0] RESP_136  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RX        = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_TX        = 2'd3
    } state_t;

    // x^7 + x^3 + 1, implicit x^7 term dropped
    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam int FRAME_LEN_48  = 48;
    localparam int FRAME_LEN_136 = 136;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0), one data bit per enabled cycle.
// Latency: crc reflects a bit on the cycle after it is presented with en=1.
// Backpressure: none; clr has priority over en.
// Ports: clk/rst (sync, active-high), clr, en, din -> crc[6:0].
module sd_crc7
    import sd_dev_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic fb;

    assign fb = din ^ crc[6];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sd_dev_cmd.sv
// Card-side SD CMD-line engine: receives 48-bit host commands, checks CRC7/end
// bit, hands index/arg to the application and serializes its response.
// Latency: rx_valid/rx_crc_err at E+1 (E = end-bit cycle); response start bit
// at max(E+NCR+1, H+1) where H is the handshake cycle.
// Backpressure: resp_ready is high from E+1 until the handshake or until the
// NCR_MAX timeout; cmd_i is ignored outside IDLE/RX.
// Ports: sd_clk, rst (sync active-high), cmd_i/cmd_o/cmd_oe pad, rx_* command
// outputs, resp_* response handshake, busy.
// Build option: define SD_DEV_R2_EN to enable 136-bit (R2) responses.
module sd_dev_cmd
    import sd_dev_pkg::*;
#(
    parameter int NCR     = 2,
    parameter int NCR_MAX = 64
) (
    input  logic         sd_clk,
    input  logic         rst,
    input  logic         cmd_i,
    output logic         cmd_o,
    output logic         cmd_oe,
    output logic         rx_valid,
    output logic [5:0]   rx_idx,
    output logic [31:0]  rx_arg,
    output logic         rx_crc_err,
    input  logic         resp_valid,
    output logic         resp_ready,
    input  logic [1:0]   resp_type,
    input  logic [5:0]   resp_idx,
    input  logic [31:0]  resp_arg,
    input  logic [119:0] resp_r2,
    output logic         busy
);

    localparam int WCNT_W = $clog2(NCR_MAX + 1);

`ifdef SD_DEV_R2_EN
    // Only frame bits down to position 8 are shifted; CRC and end bit are muxed in.
    localparam int TX_SR_W = 128;
    localparam int TXP_W   = 8;
`else
    localparam int TX_SR_W = 40;
    localparam int TXP_W   = 6;
`endif

    state_t state, state_nxt;

    logic [5:0]         rx_cnt;     // bits received so far, start bit counts as 1
    logic [45:0]        rx_sr;      // frame bit p lives at rx_sr[p-1]
    logic [WCNT_W-1:0]  wcnt;       // cycles since the end bit, 1 in E+1
    logic               have_resp;  // response captured, waiting for N_CR gap
    logic [TX_SR_W-1:0] tx_sr;
    logic [TXP_W-1:0]   tx_pos;     // frame bit position currently on the pad
    logic [TX_SR_W-1:0] tx_load;
    logic [TXP_W-1:0]   tx_pos_load;
    logic               send;
    logic               tx_crc_win;
`ifdef SD_DEV_R2_EN
    logic               tx_long;
    logic               send_long;
`else
    logic               unused_r2;
`endif

    logic [6:0] crc;
    logic       crc_clr;
    logic       crc_en;
    logic       crc_din;
    logic [7:0] tx_tail;
    logic       tx_bit;

    logic rx_done;
    logic rx_tx_bit;
    logic rx_good;
    logic hs;
    logic wait_go;
    logic timeout;

    assign rx_done   = (state == ST_RX) && (rx_cnt == 6'd47);
    assign rx_tx_bit = rx_sr[45];
    assign rx_good   = (crc == rx_sr[6:0]) && cmd_i;
    assign hs        = resp_valid && resp_ready;

`ifdef SD_DEV_R2_EN
    assign send_long   = (resp_type == RESP_136);
    assign send        = (resp_type == RESP_48) || send_long;
    assign tx_load     = send_long ? {2'b00, 6'h3F, resp_r2}
                                   : {2'b00, resp_idx, resp_arg, 88'd0};
    assign tx_pos_load = send_long ? 8'(FRAME_LEN_136 - 1) : 8'(FRAME_LEN_48 - 1);
    // R2 CRC covers only the 120 payload bits, not the 8 header bits
    assign tx_crc_win  = (tx_pos >= 8'd8) && !(tx_long && (tx_pos > 8'd127));
`else
    assign send        = (resp_type == RESP_48);
    assign tx_load     = {2'b00, resp_idx, resp_arg};
    assign tx_pos_load = 6'(FRAME_LEN_48 - 1);
    assign tx_crc_win  = (tx_pos >= 6'd8);
    assign unused_r2   = ^resp_r2;
`endif

    // A response can start once captured and the N_CR gap has elapsed;
    // the start bit itself appears the cycle after this decision.
    assign wait_go = (have_resp || (hs && send)) && (wcnt >= WCNT_W'(NCR));
    assign timeout = !have_resp && !hs && (wcnt == WCNT_W'(NCR_MAX));

    // Low frame positions: 7..1 carry the running CRC, 0 is the end bit.
    assign tx_tail = {crc, 1'b1};
    assign tx_bit  = (tx_pos >= TXP_W'(8)) ? tx_sr[TX_SR_W-1] : tx_tail[tx_pos[2:0]];

    // RX and TX never overlap, so one CRC engine serves both.
    assign crc_clr = (state == ST_IDLE) || (state == ST_WAIT_RESP);
    assign crc_en  = ((state == ST_RX) && (rx_cnt <= 6'd39)) ||
                     ((state == ST_TX) && tx_crc_win);
    assign crc_din = (state == ST_RX) ? cmd_i : tx_sr[TX_SR_W-1];

    sd_crc7 u_crc7 (
        .clk (sd_clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (crc_din),
        .crc (crc)
    );

    // State register
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!cmd_i) state_nxt = ST_RX;
            end
            ST_RX: begin
                if (rx_done) state_nxt = (rx_tx_bit && rx_good) ? ST_WAIT_RESP : ST_IDLE;
            end
            ST_WAIT_RESP: begin
                if (hs && !send)  state_nxt = ST_IDLE;
                else if (wait_go) state_nxt = ST_TX;
                else if (timeout) state_nxt = ST_IDLE;
            end
            ST_TX: begin
                if (tx_pos == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: pure decodes of registered state, so the pad sees no comb input paths.
    always_comb begin
        busy       = (state != ST_IDLE);
        resp_ready = (state == ST_WAIT_RESP) && !have_resp;
        cmd_oe     = (state == ST_TX);
        cmd_o      = (state == ST_TX) ? tx_bit : 1'b1;
    end

    // Datapath
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            rx_cnt     <= '0;
            rx_sr      <= '0;
            rx_valid   <= 1'b0;
            rx_crc_err <= 1'b0;
            rx_idx     <= '0;
            rx_arg     <= '0;
            wcnt       <= '0;
            have_resp  <= 1'b0;
            tx_sr      <= '0;
            tx_pos     <= '0;
`ifdef SD_DEV_R2_EN
            tx_long    <= 1'b0;
`endif
        end else begin
            rx_valid   <= 1'b0;
            rx_crc_err <= 1'b0;

            // The start bit is consumed in IDLE, so RX begins at count 1.
            if (state == ST_IDLE) begin
                rx_cnt <= 6'd1;
            end else if ((state == ST_RX) && !rx_done) begin
                rx_cnt <= rx_cnt + 6'd1;
                rx_sr  <= {rx_sr[44:0], cmd_i};
            end

            // Frames with transmission bit 0 are other cards' responses: no pulses.
            if (rx_done && rx_tx_bit) begin
                if (rx_good) begin
                    rx_valid <= 1'b1;
                    rx_idx   <= rx_sr[44:39];
                    rx_arg   <= rx_sr[38:7];
                end else begin
                    rx_crc_err <= 1'b1;
                end
            end

            if (state == ST_WAIT_RESP) begin
                wcnt <= wcnt + WCNT_W'(1);
                if (hs) begin
                    have_resp <= 1'b1;
                    tx_sr     <= tx_load;
                    tx_pos    <= tx_pos_load;
`ifdef SD_DEV_R2_EN
                    tx_long   <= send_long;
`endif
                end
            end else begin
                wcnt      <= WCNT_W'(1);
                have_resp <= 1'b0;
            end

            if (state == ST_TX) begin
                tx_sr  <= {tx_sr[TX_SR_W-2:0], 1'b0};
                tx_pos <= tx_pos - TXP_W'(1);
            end
        end
    end

endmodule
